// File: rtl/blocking_cache_assoc_ctrl.sv
// Miss/evict/refill controller for a blocking write-back cache: hit responds 3 cycles after accept,
// clean miss 3 + mem latency + 2; holds memreq/cacheresp until their rdy, accepts no request until RESP completes.
module blocking_cache_assoc_ctrl #(
    parameter int p_num_ways     = 2,
    parameter int p_num_sets     = 16,
    parameter int p_line_words   = 4,
    parameter int p_opaque_nbits = 8,
    localparam int c_ow  = $clog2(p_line_words * 4),
    localparam int c_iw  = $clog2(p_num_sets),
    localparam int c_wsw = (p_num_ways > 1) ? $clog2(p_num_ways) : 1,
    localparam int c_wow = $clog2(p_line_words),
    localparam int c_wbw = p_line_words * 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cachereq_val,
    output logic                  cachereq_rdy,
    input  logic [2:0]            cachereq_type,
    input  logic [31:0]           cachereq_addr,
    output logic                  cachereq_en,
    output logic                  cacheresp_val,
    input  logic                  cacheresp_rdy,
    output logic [2:0]            cacheresp_type,
    output logic                  cacheresp_hit,
    output logic                  memreq_val,
    input  logic                  memreq_rdy,
    output logic [2:0]            memreq_type,
    input  logic                  memresp_val,
    output logic                  memresp_rdy,
    output logic                  memresp_en,
    input  logic [p_num_ways-1:0] tag_match,
    output logic                  tag_array_ren,
    output logic [p_num_ways-1:0] tag_array_wen,
    output logic [c_wsw-1:0]      way_sel,
    output logic                  data_array_ren,
    output logic                  data_array_wen,
    output logic [c_wbw-1:0]      data_array_wben,
    output logic                  write_data_mux_sel,
    output logic                  evict_addr_reg_en,
    output logic                  memreq_addr_mux_sel,
    output logic                  read_data_reg_en,
    output logic [c_wow-1:0]      read_word_mux_sel
);

    if (p_num_ways != 1 && p_num_ways != 2) begin : g_bad_ways
        $error("blocking_cache_assoc_ctrl: p_num_ways must be 1 or 2");
    end
    if (p_num_sets < 2 || (p_num_sets & (p_num_sets - 1)) != 0) begin : g_bad_sets
        $error("blocking_cache_assoc_ctrl: p_num_sets must be a power of two >= 2");
    end
    if (p_line_words < 2 || p_line_words > 16 || (p_line_words & (p_line_words - 1)) != 0) begin : g_bad_line
        $error("blocking_cache_assoc_ctrl: p_line_words must be a power of two in 2..16");
    end

    typedef enum logic [3:0] {
        IDLE, TAG_CHECK, INIT_ACCESS, READ_ACCESS, WRITE_ACCESS, EVICT_PREP,
        EVICT_REQ, EVICT_WAIT, REFILL_REQ, REFILL_WAIT, REFILL_UPDATE, RESP
    } state_t;

    localparam logic [2:0] c_type_read  = 3'd0;
    localparam logic [2:0] c_type_write = 3'd1;
    localparam logic [2:0] c_type_init  = 3'd2;

    state_t                state, state_n;
    logic [c_wsw-1:0]      way, way_n, victim, hit_way;
    logic                  hit, hit_n;
    logic [2:0]            req_type, req_type_n;
    logic [p_num_ways-1:0] valid [p_num_sets];
    logic [p_num_ways-1:0] dirty [p_num_sets];
    logic                  lru   [p_num_sets];
    logic [p_num_ways-1:0] hit_vec, way_oh_n;
    logic [c_wbw-1:0]      word_wben;
    logic [c_iw-1:0]       idx;
    logic [c_wow-1:0]      word_off;
    logic                  unused_bits;

    assign idx               = cachereq_addr[c_ow+c_iw-1:c_ow];
    assign word_off          = cachereq_addr[c_ow-1:2];
    assign read_word_mux_sel = word_off;
    assign hit_vec           = tag_match & valid[idx];
    assign cacheresp_type    = req_type;
    assign cacheresp_hit     = hit;
    assign unused_bits       = (^{cachereq_addr[31:c_ow+c_iw], cachereq_addr[1:0]}) ^ (p_opaque_nbits > 0);

    // lru[idx] names the way to replace next; an invalid way always beats it, lowest index first
    always_comb begin
        hit_way = '0;
        victim  = (p_num_ways > 1) ? c_wsw'(lru[idx]) : '0;
        for (int w = p_num_ways - 1; w >= 0; w--) begin
            if (hit_vec[w])     hit_way = c_wsw'(w);
            if (!valid[idx][w]) victim  = c_wsw'(w);
        end
    end

    always_comb begin
        word_wben = '0;
        word_wben[{word_off, 2'b00} +: 4] = 4'hF;
    end

    always_comb begin
        state_n    = state;
        way_n      = way;
        hit_n      = hit;
        req_type_n = req_type;
        case (state)
            IDLE: if (cachereq_val && cachereq_rdy) begin
                state_n    = TAG_CHECK;
                req_type_n = cachereq_type;
            end
            TAG_CHECK: begin
                hit_n = |hit_vec;
                if (req_type == c_type_init) begin
                    way_n   = victim;
                    state_n = INIT_ACCESS;
                end else if (|hit_vec) begin
                    way_n   = hit_way;
                    state_n = (req_type == c_type_write) ? WRITE_ACCESS : READ_ACCESS;
                end else begin
                    way_n   = victim;
                    state_n = (valid[idx][victim] && dirty[idx][victim]) ? EVICT_PREP : REFILL_REQ;
                end
            end
            INIT_ACCESS, READ_ACCESS, WRITE_ACCESS: state_n = RESP;
            EVICT_PREP:    state_n = EVICT_REQ;
            EVICT_REQ:     if (memreq_rdy)  state_n = EVICT_WAIT;
            EVICT_WAIT:    if (memresp_val) state_n = REFILL_REQ;
            REFILL_REQ:    if (memreq_rdy)  state_n = REFILL_WAIT;
            REFILL_WAIT:   if (memresp_val) state_n = REFILL_UPDATE;
            REFILL_UPDATE: state_n = (req_type == c_type_write) ? WRITE_ACCESS : READ_ACCESS;
            RESP:          if (cacheresp_rdy) state_n = IDLE;
            default:       state_n = IDLE;
        endcase
        way_oh_n        = '0;
        way_oh_n[way_n] = 1'b1;
    end

    // outputs are decoded from the next state so every control line leaves a flop
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            way      <= '0;
            hit      <= 1'b0;
            req_type <= c_type_read;
            for (int s = 0; s < p_num_sets; s++) begin
                valid[s] <= '0;
                dirty[s] <= '0;
                lru[s]   <= 1'b0;
            end
            cachereq_rdy        <= 1'b0;
            cachereq_en         <= 1'b0;
            tag_array_ren       <= 1'b0;
            tag_array_wen       <= '0;
            way_sel             <= '0;
            data_array_ren      <= 1'b0;
            data_array_wen      <= 1'b0;
            data_array_wben     <= '0;
            write_data_mux_sel  <= 1'b0;
            evict_addr_reg_en   <= 1'b0;
            read_data_reg_en    <= 1'b0;
            memreq_val          <= 1'b0;
            memreq_type         <= 3'd0;
            memreq_addr_mux_sel <= 1'b0;
            memresp_rdy         <= 1'b0;
            memresp_en          <= 1'b0;
            cacheresp_val       <= 1'b0;
        end else begin
            state    <= state_n;
            way      <= way_n;
            hit      <= hit_n;
            req_type <= req_type_n;

            case (state)
                INIT_ACCESS: begin
                    valid[idx][way] <= 1'b1;
                    dirty[idx][way] <= 1'b0;
                    lru[idx]        <= ~way[0];
                end
                READ_ACCESS:  lru[idx] <= ~way[0];
                WRITE_ACCESS: begin
                    dirty[idx][way] <= 1'b1;
                    lru[idx]        <= ~way[0];
                end
                EVICT_WAIT: if (memresp_val) dirty[idx][way] <= 1'b0;
                REFILL_UPDATE: begin
                    valid[idx][way] <= 1'b1;
                    dirty[idx][way] <= 1'b0;
                end
                default: ;
            endcase

            cachereq_rdy        <= (state_n == IDLE);
            cachereq_en         <= (state_n == IDLE);
            tag_array_ren       <= (state_n == TAG_CHECK);
            tag_array_wen       <= (state_n == INIT_ACCESS || state_n == REFILL_UPDATE) ? way_oh_n : '0;
            way_sel             <= way_n;
            data_array_ren      <= (state_n == READ_ACCESS || state_n == EVICT_PREP);
            data_array_wen      <= (state_n == INIT_ACCESS || state_n == WRITE_ACCESS ||
                                    state_n == REFILL_UPDATE);
            data_array_wben     <= (state_n == REFILL_UPDATE) ? '1 :
                                   (state_n == INIT_ACCESS || state_n == WRITE_ACCESS) ? word_wben : '0;
            write_data_mux_sel  <= (state_n == REFILL_UPDATE);
            evict_addr_reg_en   <= (state_n == EVICT_PREP);
            read_data_reg_en    <= (state_n == READ_ACCESS || state_n == EVICT_PREP);
            memreq_val          <= (state_n == EVICT_REQ || state_n == REFILL_REQ);
            memreq_type         <= (state_n == EVICT_REQ) ? 3'd1 : 3'd0;
            memreq_addr_mux_sel <= (state_n == REFILL_REQ);
            memresp_rdy         <= (state_n == EVICT_WAIT || state_n == REFILL_WAIT);
            memresp_en          <= (state_n == REFILL_WAIT);
            cacheresp_val       <= (state_n == RESP);
        end
    end

endmodule

// File: tb/tb_blocking_cache_assoc_ctrl.sv
// Bench for blocking_cache_assoc_ctrl: scenario tasks plus scoreboards for memory requests and cache responses.
module tb_blocking_cache_assoc_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        cachereq_val, cachereq_rdy, cachereq_en;
    logic [2:0]  cachereq_type;
    logic [31:0] cachereq_addr;
    logic        cacheresp_val, cacheresp_rdy, cacheresp_hit;
    logic [2:0]  cacheresp_type;
    logic        memreq_val, memreq_rdy;
    logic [2:0]  memreq_type;
    logic        memresp_val, memresp_rdy, memresp_en;
    logic [1:0]  tag_match;
    logic        tag_array_ren;
    logic [1:0]  tag_array_wen;
    logic [0:0]  way_sel;
    logic        data_array_ren, data_array_wen;
    logic [15:0] data_array_wben;
    logic        write_data_mux_sel, evict_addr_reg_en, memreq_addr_mux_sel, read_data_reg_en;
    logic [1:0]  read_word_mux_sel;

    typedef struct {
        logic [2:0] t;
        logic       h;
    } exp_t;

    exp_t       sb[$];
    logic [2:0] mq[$];
    int         total = 0;
    int         bad = 0;
    int         mem_stall = 0;
    int         resp_stall = 0;
    logic       mem_hold = 1'b0;
    logic       pending = 1'b0;
    int         mem_scnt = 0;
    int         resp_scnt = 0;

    blocking_cache_assoc_ctrl dut (
        .clk(clk), .reset(reset),
        .cachereq_val(cachereq_val), .cachereq_rdy(cachereq_rdy), .cachereq_type(cachereq_type),
        .cachereq_addr(cachereq_addr), .cachereq_en(cachereq_en),
        .cacheresp_val(cacheresp_val), .cacheresp_rdy(cacheresp_rdy),
        .cacheresp_type(cacheresp_type), .cacheresp_hit(cacheresp_hit),
        .memreq_val(memreq_val), .memreq_rdy(memreq_rdy), .memreq_type(memreq_type),
        .memresp_val(memresp_val), .memresp_rdy(memresp_rdy), .memresp_en(memresp_en),
        .tag_match(tag_match), .tag_array_ren(tag_array_ren), .tag_array_wen(tag_array_wen),
        .way_sel(way_sel), .data_array_ren(data_array_ren), .data_array_wen(data_array_wen),
        .data_array_wben(data_array_wben), .write_data_mux_sel(write_data_mux_sel),
        .evict_addr_reg_en(evict_addr_reg_en), .memreq_addr_mux_sel(memreq_addr_mux_sel),
        .read_data_reg_en(read_data_reg_en), .read_word_mux_sel(read_word_mux_sel)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] ctl_bits();
        return {cachereq_rdy, cachereq_en, memreq_val, memresp_rdy, memresp_en, cacheresp_val,
                tag_array_ren, tag_array_wen, data_array_ren, data_array_wen, write_data_mux_sel,
                evict_addr_reg_en, memreq_addr_mux_sel, read_data_reg_en, way_sel};
    endfunction

    // memory: stalls memreq_rdy mem_stall cycles, answers one cycle after each accepted request
    initial begin
        memreq_rdy  = 1'b0;
        memresp_val = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                pending = 1'b0; memresp_val = 1'b0; memreq_rdy = 1'b0; mem_scnt = 0;
            end else begin
                memresp_val = pending && !mem_hold;
                if (memresp_val && memresp_rdy) pending = 1'b0;
                if (!memreq_val) mem_scnt = 0;
                if (memreq_val && mem_scnt < mem_stall) begin
                    mem_scnt++;
                    memreq_rdy = 1'b0;
                end else begin
                    memreq_rdy = 1'b1;
                end
                if (memreq_val && memreq_rdy) begin
                    total++;
                    if (mq.size() == 0) begin
                        bad++;
                        $display("FAIL memreq_unexpected: got type=%0d want none", memreq_type);
                    end else begin
                        logic [2:0] et;
                        et = mq.pop_front();
                        if (memreq_type !== et || memreq_addr_mux_sel !== (et == 3'd0)) begin
                            bad++;
                            $display("FAIL memreq: got type=%0d sel=%b want type=%0d sel=%b",
                                     memreq_type, memreq_addr_mux_sel, et, (et == 3'd0));
                        end
                    end
                    pending = 1'b1;
                    mem_scnt = 0;
                end
            end
        end
    end

    // response sink and scoreboard
    initial begin
        cacheresp_rdy = 1'b0;
        forever begin
            @(negedge clk);
            if (!cacheresp_val) resp_scnt = 0;
            if (cacheresp_val && resp_scnt < resp_stall) begin
                resp_scnt++;
                cacheresp_rdy = 1'b0;
            end else begin
                cacheresp_rdy = 1'b1;
            end
            if (reset && cacheresp_val && cacheresp_rdy) begin
                total++;
                resp_scnt = 0;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL resp_unexpected: got type=%0d hit=%b want none", cacheresp_type, cacheresp_hit);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (cacheresp_type !== e.t || cacheresp_hit !== e.h) begin
                        bad++;
                        $display("FAIL resp: got type=%0d hit=%b want type=%0d hit=%b",
                                 cacheresp_type, cacheresp_hit, e.t, e.h);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want test end");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        cachereq_val = 1'b0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic issue(input logic [2:0] t, input logic [31:0] a, input logic [1:0] tm, input logic eh);
        int n;
        @(negedge clk);
        cachereq_val = 1'b1; cachereq_type = t; cachereq_addr = a; tag_match = tm;
        n = 0;
        while (!cachereq_rdy && n < 100) begin @(negedge clk); n++; end
        if (!cachereq_rdy) begin
            total++; bad++;
            $display("FAIL accept: got rdy=0 want rdy=1 addr=%h", a);
        end
        sb.push_back(exp_t'{t, eh});
        @(negedge clk);
        cachereq_val = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        while ((sb.size() != 0 || mq.size() != 0 || !cachereq_rdy) && n < 300) begin @(negedge clk); n++; end
        total++;
        if (sb.size() != 0 || mq.size() != 0 || !cachereq_rdy) begin
            bad++;
            $display("FAIL %s_drain: got resp_left=%0d memreq_left=%0d rdy=%b want 0 0 1",
                     nm, sb.size(), mq.size(), cachereq_rdy);
        end
    endtask

    task automatic test_reset();
        int n;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (ctl_bits() !== 17'd0) begin bad++; $display("FAIL reset_ctl: got %b want 0", ctl_bits()); end
        total++;
        if (data_array_wben !== 16'h0 || memreq_type !== 3'd0) begin
            bad++; $display("FAIL reset_wben: got wben=%h type=%0d want 0 0", data_array_wben, memreq_type);
        end
        reset = 1'b1;
        mq.push_back(3'd0);
        issue(3'd0, 32'h0000_1004, 2'b00, 1'b0);
        n = 1;
        while (!memreq_val && n < 10) begin @(negedge clk); n++; end
        total++;
        if (!memreq_val || n > 3 || memreq_type !== 3'd0) begin
            bad++; $display("FAIL reset_miss_req: got val=%b cycle=%0d type=%0d want 1 <=3 0", memreq_val, n, memreq_type);
        end
        total++;
        if (read_word_mux_sel !== 2'd1) begin bad++; $display("FAIL reset_word_sel: got %0d want 1", read_word_mux_sel); end
        wait_done("reset");
    endtask

    task automatic test_hit();
        int n;
        do_reset();
        issue(3'd2, 32'h0000_1000, 2'b00, 1'b0);
        wait_done("hit_init");
        issue(3'd0, 32'h0000_1000, 2'b01, 1'b1);
        n = 1;
        while (!cacheresp_val && n < 10) begin @(negedge clk); n++; end
        total++;
        if (!cacheresp_val || n != 3) begin bad++; $display("FAIL hit_latency: got val=%b cycle=%0d want 1 3", cacheresp_val, n); end
        total++;
        if (way_sel !== 1'b0 || read_word_mux_sel !== 2'd0 || cacheresp_hit !== 1'b1) begin
            bad++; $display("FAIL hit_fields: got way=%0d word=%0d hit=%b want 0 0 1", way_sel, read_word_mux_sel, cacheresp_hit);
        end
        wait_done("hit");
    endtask

    task automatic test_assoc();
        int n;
        do_reset();
        issue(3'd2, 32'h0000_1000, 2'b00, 1'b0);
        wait_done("assoc_init0");
        issue(3'd2, 32'h0000_2000, 2'b00, 1'b0);
        n = 0;
        while (tag_array_wen === 2'b00 && n < 10) begin @(negedge clk); n++; end
        total++;
        if (tag_array_wen !== 2'b10) begin bad++; $display("FAIL assoc_init_way: got wen=%b want 10", tag_array_wen); end
        wait_done("assoc_init1");
        issue(3'd0, 32'h0000_1000, 2'b01, 1'b1);
        wait_done("assoc_hit");
        mq.push_back(3'd0);
        issue(3'd0, 32'h0000_3000, 2'b00, 1'b0);
        n = 0;
        while (tag_array_wen === 2'b00 && n < 20) begin @(negedge clk); n++; end
        total++;
        if (tag_array_wen !== 2'b10 || way_sel !== 1'b1 || write_data_mux_sel !== 1'b1) begin
            bad++; $display("FAIL assoc_victim: got wen=%b way=%0d wsel=%b want 10 1 1", tag_array_wen, way_sel, write_data_mux_sel);
        end
        wait_done("assoc_miss");
    endtask

    task automatic test_dirty_evict();
        int n;
        issue(3'd1, 32'h0000_1008, 2'b01, 1'b1);
        wait_done("evict_write_hit");
        issue(3'd0, 32'h0000_3000, 2'b10, 1'b1);
        wait_done("evict_touch_way1");
        mq.push_back(3'd1);
        mq.push_back(3'd0);
        issue(3'd1, 32'h0000_4008, 2'b00, 1'b0);
        n = 0;
        while (!(data_array_wen && !write_data_mux_sel) && n < 30) begin @(negedge clk); n++; end
        total++;
        if (data_array_wben !== 16'h0F00 || way_sel !== 1'b0 || !data_array_wen) begin
            bad++; $display("FAIL evict_write_wben: got wben=%h way=%0d wen=%b want 0f00 0 1", data_array_wben, way_sel, data_array_wen);
        end
        wait_done("evict");
    endtask

    task automatic test_backpressure();
        int n;
        do_reset();
        mem_stall = 5;
        resp_stall = 4;
        mq.push_back(3'd0);
        issue(3'd0, 32'h0000_5010, 2'b00, 1'b0);
        n = 0;
        while (!memreq_val && n < 10) begin @(negedge clk); n++; end
        for (int i = 0; i < 5; i++) begin
            total++;
            if ({memreq_val, memreq_type, cachereq_rdy} !== 5'b1_000_0) begin
                bad++; $display("FAIL bp_memreq_hold%0d: got val=%b type=%0d rdy=%b want 1 0 0", i, memreq_val, memreq_type, cachereq_rdy);
            end
            @(negedge clk);
        end
        n = 0;
        while (!cacheresp_val && n < 30) begin @(negedge clk); n++; end
        for (int i = 0; i < 4; i++) begin
            total++;
            if ({cacheresp_val, cacheresp_type, cacheresp_hit, cachereq_rdy} !== 6'b1_000_0_0) begin
                bad++; $display("FAIL bp_resp_hold%0d: got val=%b type=%0d hit=%b rdy=%b want 1 0 0 0",
                                i, cacheresp_val, cacheresp_type, cacheresp_hit, cachereq_rdy);
            end
            @(negedge clk);
        end
        wait_done("bp");
        mem_stall = 0;
        resp_stall = 0;
    endtask

    task automatic test_reset_mid_miss();
        int n;
        do_reset();
        mem_hold = 1'b1;
        mq.push_back(3'd0);
        issue(3'd0, 32'h0000_6020, 2'b00, 1'b0);
        n = 0;
        while (!memresp_en && n < 20) begin @(negedge clk); n++; end
        total++;
        if (!memresp_en || !memresp_rdy) begin bad++; $display("FAIL abort_refill_wait: got en=%b rdy=%b want 1 1", memresp_en, memresp_rdy); end
        #2 reset = 1'b0;
        #1;
        total++;
        if (ctl_bits() !== 17'd0 || data_array_wben !== 16'h0) begin
            bad++; $display("FAIL abort_async_clear: got ctl=%b wben=%h want 0 0", ctl_bits(), data_array_wben);
        end
        if (sb.size() != 0) void'(sb.pop_back());
        repeat (2) @(negedge clk);
        reset = 1'b1;
        mem_hold = 1'b0;
        @(negedge clk);
        total++;
        if ({memreq_val, cachereq_rdy} !== 2'b01) begin
            bad++; $display("FAIL abort_release: got memreq_val=%b rdy=%b want 0 1", memreq_val, cachereq_rdy);
        end
        mq.push_back(3'd0);
        issue(3'd0, 32'h0000_6020, 2'b01, 1'b0);
        wait_done("abort_refetch");
    endtask

    initial begin
        reset = 1'b0;
        cachereq_val = 1'b0;
        cachereq_type = 3'd0;
        cachereq_addr = 32'h0;
        tag_match = 2'b00;
        test_reset();
        test_hit();
        test_assoc();
        test_dirty_evict();
        test_backpressure();
        test_reset_mid_miss();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
